// File: rtl/prog_loader.sv
// Boot-time program loader: consumes a byte stream (16-bit word count, then words,
// all high byte first) and writes the words into program memory while holding the CPU in reset.
module prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [15:0]       pm_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg
);

    // Handshake: a byte moves on a rising edge only when byte_valid && byte_ready;
    // byte_ready depends on the state alone, never on byte_valid.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DAT_HI = 3'd3,
        S_DAT_LO = 3'd4,
        S_WRITE  = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        n_hi;
    logic [15:0]       n_reg;
    logic [15:0]       n_hdr;
    logic [ADDR_W:0]   idx;
    logic [7:0]        hi_byte;
    logic              accept;
    logic              last_word;

    assign accept    = byte_valid && byte_ready;
    assign n_hdr     = {n_hi, byte_in};
    // idx is one bit wider than pm_addr so a full 2^ADDR_W load ends without wrapping.
    assign last_word = ({{(31 - ADDR_W){1'b0}}, idx} + 32'd1) == {16'd0, n_reg};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_nxt = S_HDR_HI;
            end
            S_HDR_HI: if (accept) state_nxt = S_HDR_LO;
            S_HDR_LO: begin
                if (accept) begin
                    if (n_hdr == 16'd0)                  state_nxt = S_DONE;
                    else if ({1'b0, n_hdr} > MAX_WORDS)  state_nxt = S_ERR;
                    else                                 state_nxt = S_DAT_HI;
                end
            end
            S_DAT_HI: if (accept) state_nxt = S_DAT_LO;
            S_DAT_LO: if (accept) state_nxt = S_WRITE;
            S_WRITE:  state_nxt = last_word ? S_DONE : S_DAT_HI;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        pm_we      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_reset  = 1'b1;
        state_dbg  = state;
        case (state)
            S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            S_WRITE: begin
                busy  = 1'b1;
                pm_we = 1'b1;
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

    // The high data byte is staged so pm_wdata/pm_addr only change when a full word is ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_hi     <= '0;
            n_reg    <= '0;
            idx      <= '0;
            hi_byte  <= '0;
            pm_addr  <= '0;
            pm_wdata <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) idx <= '0;
                end
                S_HDR_HI: if (accept) n_hi <= byte_in;
                S_HDR_LO: if (accept) n_reg <= n_hdr;
                S_DAT_HI: if (accept) hi_byte <= byte_in;
                S_DAT_LO: begin
                    if (accept) begin
                        pm_wdata <= {hi_byte, byte_in};
                        pm_addr  <= idx[ADDR_W-1:0];
                    end
                end
                S_WRITE: if (!last_word) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: each task runs one scenario and checks its own results.
module tb_prog_loader;

    localparam int AW = 10;
    localparam int W  = AW + 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          pm_we;
    logic [AW-1:0] pm_addr;
    logic [15:0]   pm_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    state_dbg;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0]   tx_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] wr_q[$];
    int           wr_cyc_q[$];

    prog_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .pm_we(pm_we),
        .pm_addr(pm_addr), .pm_wdata(pm_wdata), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // write monitor
    always @(negedge clk) begin
        if (pm_we === 1'b1) begin
            wr_q.push_back({pm_addr, pm_wdata});
            wr_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic clear_logs();
        wr_q.delete();
        wr_cyc_q.delete();
        exp_q.delete();
        tx_q.delete();
    endtask

    task automatic start_session();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_bytes(input bit rnd_valid, input bit rnd_start);
        int   i = 0;
        int   budget = 0;
        logic v;
        logic rdy;
        while (i < tx_q.size()) begin
            @(negedge clk);
            v          = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_in    = tx_q[i];
            byte_valid = v;
            start      = rnd_start ? 1'($urandom_range(0, 2) == 0) : 1'b0;
            rdy        = byte_ready;
            @(posedge clk);
            if (v && rdy) i++;
            budget++;
            if (budget > 20000) begin
                tests++; fails++;
                $display("FAIL send_timeout: sent %0d of %0d bytes", i, tx_q.size());
                break;
            end
        end
        #1;
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 8; k++) begin
            if (done === 1'b1) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [AW-1:0] a, input logic [15:0] d);
        tx_q.push_back(d[15:8]);
        tx_q.push_back(d[7:0]);
        exp_q.push_back({a, d});
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_in = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (state_dbg !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        tests++; if (pm_we !== 1'b0) begin fails++; $display("FAIL reset_pm_we: got %b want 0", pm_we); end
        tests++; if (pm_addr !== '0) begin fails++; $display("FAIL reset_pm_addr: got %h want 0", pm_addr); end
        tests++; if (pm_wdata !== 16'h0) begin fails++; $display("FAIL reset_pm_wdata: got %h want 0", pm_wdata); end
        tests++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", byte_ready); end
        tests++; if ({busy, done, err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
        tests++; if (cpu_reset !== 1'b1) begin fails++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        @(negedge clk);
        reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (state_dbg !== 3'd0) begin fails++; $display("FAIL idle_hold: got %0d want 0", state_dbg); end
    endtask

    task automatic test_basic();
        clear_logs();
        start_session();
        tests++; if (state_dbg !== 3'd1) begin fails++; $display("FAIL basic_hdr_hi: got %0d want 1", state_dbg); end
        tests++; if ({busy, cpu_reset, byte_ready} !== 3'b111) begin fails++; $display("FAIL basic_busy: got %b want 111", {busy, cpu_reset, byte_ready}); end
        tx_q = '{8'h00, 8'h02};
        push_word(10'h000, 16'h1234);
        push_word(10'h001, 16'hABCD);
        send_bytes(1'b0, 1'b0);
        wait_done();
        tests++; if (wr_q.size() !== 2) begin fails++; $display("FAIL basic_count: got %0d want 2", wr_q.size()); end
        for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
            tests++; if (wr_q[k] !== exp_q[k]) begin fails++; $display("FAIL basic_write%0d: got %h want %h", k, wr_q[k], exp_q[k]); end
        end
        if (wr_cyc_q.size() == 2) begin
            tests++; if (wr_cyc_q[1] - wr_cyc_q[0] !== 3) begin fails++; $display("FAIL basic_spacing: got %0d want 3", wr_cyc_q[1] - wr_cyc_q[0]); end
        end
        tests++; if ({done, err, cpu_reset, busy} !== 4'b1000) begin fails++; $display("FAIL basic_done: got %b want 1000", {done, err, cpu_reset, busy}); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if ({done, cpu_reset} !== 2'b10) begin fails++; $display("FAIL basic_done_hold: got %b want 10", {done, cpu_reset}); end
        tests++; if (pm_wdata !== 16'hABCD) begin fails++; $display("FAIL basic_wdata_hold: got %h want abcd", pm_wdata); end
    endtask

    task automatic test_zero_count();
        clear_logs();
        start_session();
        tests++; if ({done, cpu_reset} !== 2'b01) begin fails++; $display("FAIL zero_start_clear: got %b want 01", {done, cpu_reset}); end
        tx_q = '{8'h00, 8'h00};
        send_bytes(1'b0, 1'b0);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b want 1", done); end
        tests++; if (state_dbg !== 3'd6) begin fails++; $display("FAIL zero_state: got %0d want 6", state_dbg); end
        repeat (2) @(posedge clk);
        #1;
        tests++; if (wr_q.size() !== 0) begin fails++; $display("FAIL zero_writes: got %0d want 0", wr_q.size()); end
    endtask

    task automatic test_oversize_then_full();
        int bad;
        clear_logs();
        start_session();
        tx_q = '{8'h04, 8'h01};
        send_bytes(1'b0, 1'b0);
        tests++; if ({err, done, cpu_reset} !== 3'b101) begin fails++; $display("FAIL over_err: got %b want 101", {err, done, cpu_reset}); end
        @(negedge clk);
        byte_valid = 1'b1; byte_in = 8'h55;
        repeat (4) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        tests++; if (wr_q.size() !== 0) begin fails++; $display("FAIL over_writes: got %0d want 0", wr_q.size()); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL over_err_hold: got %b want 1", err); end
        start_session();
        tests++; if ({state_dbg, err, busy} !== 5'b001_0_1) begin fails++; $display("FAIL over_restart: got %b want 00101", {state_dbg, err, busy}); end
        // max-size load: N = 1024
        clear_logs();
        tx_q = '{8'h04, 8'h00};
        for (int k = 0; k < 1024; k++) push_word(AW'(k), 16'(k) + 16'h1000);
        send_bytes(1'b0, 1'b0);
        wait_done();
        tests++; if (wr_q.size() !== 1024) begin fails++; $display("FAIL full_count: got %0d want 1024", wr_q.size()); end
        bad = 0;
        for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) if (wr_q[k] !== exp_q[k]) bad++;
        tests++; if (bad !== 0) begin fails++; $display("FAIL full_data: got %0d bad words want 0", bad); end
        if (wr_q.size() > 0) begin
            tests++; if (wr_q[wr_q.size()-1] !== {10'h3FF, 16'h13FF}) begin fails++; $display("FAIL full_last: got %h want %h", wr_q[wr_q.size()-1], {10'h3FF, 16'h13FF}); end
        end
        tests++; if ({done, cpu_reset} !== 2'b10) begin fails++; $display("FAIL full_done: got %b want 10", {done, cpu_reset}); end
    endtask

    task automatic test_random_valid();
        clear_logs();
        start_session();
        tx_q = '{8'h00, 8'h06};
        for (int k = 0; k < 6; k++) push_word(AW'(k), 16'($urandom_range(0, 65535)));
        send_bytes(1'b1, 1'b1);
        wait_done();
        tests++; if (wr_q.size() !== 6) begin fails++; $display("FAIL rand_count: got %0d want 6", wr_q.size()); end
        for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
            tests++; if (wr_q[k] !== exp_q[k]) begin fails++; $display("FAIL rand_write%0d: got %h want %h", k, wr_q[k], exp_q[k]); end
        end
        tests++; if ({done, err, cpu_reset} !== 3'b100) begin fails++; $display("FAIL rand_done: got %b want 100", {done, err, cpu_reset}); end
    endtask

    task automatic test_reset_mid_session();
        clear_logs();
        start_session();
        tx_q = '{8'h00, 8'h08};
        for (int k = 0; k < 5; k++) push_word(AW'(k), 16'hC000 + 16'(k));
        tx_q.push_back(8'h5A);
        send_bytes(1'b0, 1'b0);
        tests++; if (state_dbg !== 3'd4) begin fails++; $display("FAIL mid_pre_state: got %0d want 4", state_dbg); end
        @(negedge clk);
        reset = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_in = 8'hA5;
        @(posedge clk);
        #1;
        tests++; if (state_dbg !== 3'd0) begin fails++; $display("FAIL mid_state: got %0d want 0", state_dbg); end
        tests++; if ({pm_we, busy, cpu_reset} !== 3'b001) begin fails++; $display("FAIL mid_outputs: got %b want 001", {pm_we, busy, cpu_reset}); end
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        tests++; if (wr_q.size() !== 5) begin fails++; $display("FAIL mid_count: got %0d want 5", wr_q.size()); end
        for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
            tests++; if (wr_q[k] !== exp_q[k]) begin fails++; $display("FAIL mid_write%0d: got %h want %h", k, wr_q[k], exp_q[k]); end
        end
        tests++; if ({state_dbg, cpu_reset} !== 4'b000_1) begin fails++; $display("FAIL mid_idle_hold: got %b want 0001", {state_dbg, cpu_reset}); end
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_oversize_then_full();
        test_random_valid();
        test_reset_mid_session();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
